// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0;
  localparam int          DEFAULT_ADDR_W   = 9;
  localparam int          DEFAULT_RESET_PC = 0;

  // One buffered fetch: the instruction word and its zero-extended return PC.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus1;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched instructions; flush wins over push, and a pop frees
// its slot so push+pop at full is legal.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int CW    = $clog2(QDEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t pushData,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int PW = $clog2(QDEPTH);

  fetch_entry_t   entries [QDEPTH];
  logic [PW-1:0]  rdPtr;
  logic [PW-1:0]  wrPtr;
  logic           doPop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign doPop = pop & (count != '0);
  assign head  = entries[rdPtr];

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= bump(wrPtr);
      if (doPop) rdPtr <= bump(rdPtr);
      count <= count + CW'(push) - CW'(doPop);
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) entries[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues word reads, tags in-flight reads with an
// epoch so redirects can discard stale returns, and feeds decode from a queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int QDEPTH   = 2,
  parameter int RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              fd_valid,
  output logic [31:0]       fd_instr,
  output logic [31:0]       fd_pc
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inFlightAddr;
  logic [ADDR_W-1:0] retPcPlus1;
  logic              inFlight;
  logic              inFlightEpoch;
  logic              epoch;
  logic [CW-1:0]     qCount;
  fetch_entry_t      qHead;
  fetch_entry_t      qPushData;
  logic              qPush;
  logic              popReq;
  logic              fdValid;
  logic [CW:0]       occupancy;
  logic [CW:0]       issueLimit;

  assign fdValid    = ~reset & (qCount != '0);
  assign popReq     = fdValid & ~stall & ~redirect_valid;
  assign occupancy  = (CW+1)'(qCount) + (CW+1)'(inFlight);
  assign issueLimit = (CW+1)'(QDEPTH) + (CW+1)'(popReq);
  assign imem_req   = ~reset & ~redirect_valid & (occupancy < issueLimit);
  assign imem_addr  = pc;

  assign qPush      = inFlight & (inFlightEpoch == epoch);
  assign retPcPlus1 = inFlightAddr + ADDR_W'(1);
  assign qPushData  = '{instr: imem_rdata, pc_plus1: 32'(retPcPlus1)};

  // PC, epoch and in-flight tracking; a redirect reloads the PC and retires
  // the current epoch so any read already issued is ignored on return.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= ADDR_W'(RESET_PC);
      epoch         <= 1'b0;
      inFlight      <= 1'b0;
      inFlightEpoch <= 1'b0;
      inFlightAddr  <= '0;
    end else begin
      inFlight      <= imem_req;
      inFlightAddr  <= pc;
      inFlightEpoch <= epoch;
      if (redirect_valid) begin
        pc    <= redirect_pc;
        epoch <= ~epoch;
      end else if (imem_req) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) uQueue (
    .clk      (clk),
    .reset    (reset),
    .push     (qPush),
    .pushData (qPushData),
    .pop      (popReq),
    .flush    (redirect_valid),
    .count    (qCount),
    .head     (qHead)
  );

  assign fd_valid = fdValid;
  assign fd_instr = fdValid ? qHead.instr    : NOP_INSTR;
  assign fd_pc    = fdValid ? qHead.pc_plus1 : 32'h0;

endmodule
